// File: rtl/part_2_xfer_sched.sv
// Purpose : round-robin scheduler of fringe put/get exchanges for four mission clocks, freezing each domain until its exchange completes.
// Latency : pending set -> first xfer_start_o strobe is 2 cycles (IDLE grant, then REQ); rcv_valid_o pulses the cycle after a valid get completion.
// Backpressure: each phase waits indefinitely for xfer_done_i, except the get phase, which is bounded by a WD_LIMIT-cycle watchdog (ERR is terminal).
// Ports   : clk_i/rst_i utility clock and sync reset; clk_h_i/clk_en_i mission clock levels and enables;
//           put_en_i/get_en_i phase selects; xfer_* transaction channel to the fringe transport;
//           freeze_clk_o/rcv_valid_o/ovr_o per-domain status; wd_err_o sticky watchdog error; busy_o FSM not idle.
module part_2_xfer_sched #(
    parameter int N_CLK    = 4,
    parameter int WD_LIMIT = 10000,
    parameter int WD_W     = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_CLK-1:0] clk_h_i,
    input  logic [N_CLK-1:0] clk_en_i,
    input  logic             put_en_i,
    input  logic             get_en_i,
    output logic             xfer_start_o,
    output logic             xfer_dir_o,
    output logic [1:0]       xfer_idx_o,
    input  logic             xfer_done_i,
    input  logic             xfer_valid_i,
    output logic [N_CLK-1:0] freeze_clk_o,
    output logic [N_CLK-1:0] rcv_valid_o,
    output logic [N_CLK-1:0] ovr_o,
    output logic             wd_err_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUT_REQ, S_PUT_WAIT, S_GET_REQ, S_GET_WAIT, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [N_CLK-1:0] clk_h_q;
    logic [N_CLK-1:0] pending_q, pending_d;
    logic [N_CLK-1:0] ovr_q, ovr_d;
    logic [N_CLK-1:0] rcv_q, rcv_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             wd_err_q, wd_err_d;

    logic [N_CLK-1:0] qrise;
    logic [N_CLK-1:0] clr_mask;
    logic [1:0]       pick;
    logic [1:0]       cand;

    assign qrise = clk_h_i & ~clk_h_q & clk_en_i;

    // Scan downwards so the candidate closest after last_grant is written last and wins.
    always_comb begin
        pick = last_grant_q;
        cand = last_grant_q;
        for (int k = N_CLK; k >= 1; k--) begin
            cand = last_grant_q + 2'(k);
            if (pending_q[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        wd_err_d     = wd_err_q;
        rcv_d        = '0;
        clr_mask     = '0;
        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (|pending_q) begin
                    grant_d = pick;
                    if (put_en_i)      state_d = S_PUT_REQ;
                    else if (get_en_i) state_d = S_GET_REQ;
                    else               state_d = S_DONE;
                end
            end
            S_PUT_REQ: state_d = S_PUT_WAIT;
            S_PUT_WAIT: begin
                if (xfer_done_i) begin
                    state_d = get_en_i ? S_GET_REQ : S_DONE;
                end
            end
            S_GET_REQ, S_GET_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (state_q == S_GET_REQ) begin
                    state_d = S_GET_WAIT;
                end else if (xfer_done_i) begin
                    if (xfer_valid_i) begin
                        rcv_d[grant_q] = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        state_d = S_GET_REQ;
                    end
                end
                // Watchdog expiry overrides any completion seen in the same cycle.
                if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                    state_d  = S_ERR;
                    wd_err_d = 1'b1;
                    rcv_d    = '0;
                end
            end
            S_DONE: begin
                clr_mask[grant_q] = 1'b1;
                last_grant_d      = grant_q;
                state_d           = S_IDLE;
            end
            default: state_d = S_ERR;
        endcase
    end

    // A qualified rise on the domain being retired in DONE re-arms it without counting as overrun.
    always_comb begin
        pending_d = pending_q;
        ovr_d     = ovr_q;
        if (state_q != S_ERR) begin
            pending_d = (pending_q & ~clr_mask) | qrise;
            ovr_d     = ovr_q | (qrise & pending_q & ~clr_mask);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            clk_h_q      <= '0;
            pending_q    <= '0;
            ovr_q        <= '0;
            rcv_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= 2'(N_CLK - 1);
            wd_q         <= '0;
            wd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_h_q      <= clk_h_i;
            pending_q    <= pending_d;
            ovr_q        <= ovr_d;
            rcv_q        <= rcv_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            wd_err_q     <= wd_err_d;
        end
    end

    // Strobes are masked during reset so a REQ state being abandoned never leaks a request.
    assign xfer_start_o = ~rst_i & ((state_q == S_PUT_REQ) | (state_q == S_GET_REQ));
    assign xfer_dir_o   = ~rst_i & (state_q == S_PUT_REQ);
    assign xfer_idx_o   = grant_q;
    assign freeze_clk_o = pending_q;
    assign rcv_valid_o  = rcv_q;
    assign ovr_o        = ovr_q;
    assign wd_err_o     = wd_err_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: doc/part_2_xfer_sched.md
Name: part_2_xfer_sched

Overview:
- Schedules fringe get/put transactions for the four mission clocks of a part_2 target partition (clk_0_h..clk_3_h).
- Detects rising edges of the mission clocks in the utility clock domain and freezes each domain while its exchange is outstanding.
- Arbitrates the single shared fringe transaction channel round-robin, with a per-grant polling watchdog.
- Sits between the target interface's mission-clock logic and the fringe transport.

Parameters:
- N_CLK, 4, number of mission clocks / event slots (index width fixed at 2 bits).
- WD_LIMIT, 10000, maximum utility cycles allowed in the get phase of one grant before a fatal error.
- WD_W, 14, watchdog counter width; must satisfy 2^WD_W > WD_LIMIT.

Ports:
- clk_i, input, 1: utility clock; all logic on its rising edge.
- rst_i, input, 1: synchronous, active-high reset.
- clk_h_i, input, N_CLK: mission clock levels, sampled on clk_i.
- clk_en_i, input, N_CLK: per-domain scheduling enable.
- put_en_i, input, 1: perform a put (send vector) phase per grant.
- get_en_i, input, 1: perform a get (receive vector) phase per grant.
- xfer_start_o, output, 1: one-cycle transaction request strobe.
- xfer_dir_o, output, 1: 1=put, 0=get; valid with xfer_start_o.
- xfer_idx_o, output, 2: event index of the current grant.
- xfer_done_i, input, 1: transport finished the requested transaction.
- xfer_valid_i, input, 1: with xfer_done_i on a get, data was present.
- freeze_clk_o, output, N_CLK: hold mission clock i.
- rcv_valid_o, output, N_CLK: one-cycle pulse when a get for domain i delivers data.
- ovr_o, output, N_CLK: sticky; edge arrived while domain already pending.
- wd_err_o, output, 1: sticky watchdog error.
- busy_o, output, 1: FSM not in IDLE.

Behaviour:
Reset:
- All outputs 0.
- clk_h_d, pending, grant and watchdog cleared.
- last_grant=N_CLK-1, so the first grant goes to index 0.
- State=IDLE.
- Reset mid-transaction abandons it; no strobe is issued in the reset cycle.

Edge detection:
- rise[i] = clk_h_i[i] & ~clk_h_d[i]; clk_h_d is registered each cycle.
- If rise[i] & clk_en_i[i]: pending[i] and freeze_clk_o[i] set on the next clk_i edge.
- A disabled domain's edge is ignored.
- rise[i] while pending[i] already set: merge (no second request), ovr_o[i]<=1.

FSM states: IDLE, PUT_REQ, PUT_WAIT, GET_REQ, GET_WAIT, DONE, ERR.
- IDLE: if any pending, grant g = first pending index searching last_grant+1, +2, ... with wrap. Next state is PUT_REQ if put_en_i, else GET_REQ if get_en_i, else DONE. Watchdog <= 0.
- PUT_REQ: xfer_start_o=1, xfer_dir_o=1, xfer_idx_o=g. Next: PUT_WAIT.
- PUT_WAIT: on xfer_done_i go to GET_REQ if get_en_i, else DONE.
- GET_REQ: xfer_start_o=1, xfer_dir_o=0. Next: GET_WAIT.
- GET_WAIT:
  - On xfer_done_i & xfer_valid_i: rcv_valid_o[g] pulses the next cycle; next state DONE.
  - On xfer_done_i & ~xfer_valid_i: next state GET_REQ (re-poll).
- Watchdog: increments every cycle spent in GET_REQ/GET_WAIT. When it reaches WD_LIMIT: next state ERR, wd_err_o<=1.
- DONE: pending[g]<=0, freeze_clk_o[g]<=0, last_grant<=g. Next: IDLE.
  - A new qualified rise[g] in the same cycle wins: pending[g] and freeze stay 1, ovr not set.
- ERR: terminal until rst_i. No strobes. freeze_clk_o holds its current value. busy_o=1.

Other rules:
- xfer_idx_o holds g from grant to DONE.
- xfer_done_i outside the WAIT states is ignored.
- xfer_start_o is never asserted on two consecutive cycles.
- Minimum grant latency: pending set to first strobe is 2 cycles (IDLE, then REQ).

Test Plan:
- Single domain, put+get: put_en=get_en=1, one rise on clk_h_i[0], done after 2 cycles each, valid=1 → strobes put idx0 then get idx0; rcv_valid_o[0] pulse; freeze_clk_o[0] high from cycle after edge until DONE.
- Round-robin: simultaneous rises on 0 and 2, then 0 again during service → grant order 0, 2, 0; no ovr.
- Get polling: get only; three done with valid=0, then valid=1 → four get strobes on idx g, one rcv_valid pulse, no wd_err.
- Watchdog: WD_LIMIT=16, valid never asserted → ERR after 16 get-phase cycles; wd_err_o=1 held; further edges produce no strobes.
- Overrun and DONE collision: second rise on pending domain 1 before service → ovr_o[1]=1, single grant. Rise on g in DONE cycle → pending stays set, regrant later, ovr stays 0.
- Reset mid GET_WAIT: assert rst_i one cycle → all outputs 0; next rise on 3 is granted idx 3 normally.
